// File: rtl/enc8b10b_pkg.sv
// Shared constants for the 8b/10b transmit path: K-character codes and controller states.
package enc8b10b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle / fill
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
    localparam logic [7:0] K30_7 = 8'hFE;  // frame abort

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_ALIGN,
        ST_IDLE,
        ST_DATA,
        ST_EOF,
        ST_ABORT
    } tx_state_t;

endpackage

// File: rtl/enc8b10b_tx_ctrl_if.sv
// Requester and encoder-side signal bundle for the 8b/10b transmit controller.
interface enc8b10b_tx_ctrl_if;

    logic [7:0] s0_data;
    logic       s0_valid;
    logic       s0_last;
    logic       s0_ready;
    logic [7:0] s1_data;
    logic       s1_valid;
    logic       s1_last;
    logic       s1_ready;
    logic [7:0] enc_data;
    logic       enc_k;
    logic       enc_valid;
    logic       enc_enable;
    logic       aligned;
    logic       busy;

    // Requester side: supplies payload, observes acceptance and link status.
    modport master (
        output s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last,
        input  s0_ready, s1_ready, enc_data, enc_k, enc_valid, enc_enable, aligned, busy
    );

    // Controller side: consumes payload, drives encoder symbols and status.
    modport slave (
        input  s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last,
        output s0_ready, s1_ready, enc_data, enc_k, enc_valid, enc_enable, aligned, busy
    );

endinterface

// File: rtl/enc8b10b_rr_arb.sv
// Two-requester round-robin arbiter; pointer moves past the served source on each update strobe.
module enc8b10b_rr_arb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic       upd_i,
    input  logic       served_i,
    output logic       grant_o
);

    logic ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else if (upd_i) begin
            ptr_q <= ~served_i;
        end
    end

    always_comb begin
        grant_o = ptr_q;
        case (valid_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            default: grant_o = ptr_q;
        endcase
    end

endmodule

// File: rtl/enc8b10b_tx_ctrl.sv
// 8b/10b transmit controller: comma alignment after link enable, then framed packets
// from two round-robin requesters with K-character SOF/EOF/fill/abort symbols.
module enc8b10b_tx_ctrl
    import enc8b10b_pkg::*;
#(
    parameter int unsigned ALIGN_LEN = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       link_en_i,
    input  logic [7:0] s0_data_i,
    input  logic       s0_valid_i,
    input  logic       s0_last_i,
    output logic       s0_ready_o,
    input  logic [7:0] s1_data_i,
    input  logic       s1_valid_i,
    input  logic       s1_last_i,
    output logic       s1_ready_o,
    output logic [7:0] enc_data_o,
    output logic       enc_k_o,
    output logic       enc_valid_o,
    output logic       enc_enable_o,
    output logic       aligned_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W = $clog2(ALIGN_LEN + 2);

    tx_state_t        state;
    logic [CNT_W-1:0] align_cnt;
    logic             gnt_q;
    logic             arb_grant;
    logic             arb_upd;
    logic             data_ok;
    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;

    always_comb begin
        data_ok    = (state == ST_DATA) && link_en_i;
        s0_ready_o = data_ok && !gnt_q;
        s1_ready_o = data_ok && gnt_q;
        sel_data   = gnt_q ? s1_data_i  : s0_data_i;
        sel_valid  = gnt_q ? s1_valid_i : s0_valid_i;
        sel_last   = gnt_q ? s1_last_i  : s0_last_i;
        arb_upd    = ((state == ST_DATA) && !link_en_i) || (state == ST_EOF);
    end

    enc8b10b_rr_arb u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  ({s1_valid_i, s0_valid_i}),
        .upd_i    (arb_upd),
        .served_i (gnt_q),
        .grant_o  (arb_grant)
    );

    // Symbol registers default to "link off" each cycle; states override with their symbol.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_DISABLED;
            align_cnt    <= '0;
            gnt_q        <= 1'b0;
            enc_data_o   <= '0;
            enc_k_o      <= 1'b0;
            enc_valid_o  <= 1'b0;
            enc_enable_o <= 1'b0;
            aligned_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            enc_data_o   <= '0;
            enc_k_o      <= 1'b0;
            enc_valid_o  <= 1'b0;
            enc_enable_o <= 1'b0;
            case (state)
                ST_DISABLED: begin
                    aligned_o <= 1'b0;
                    busy_o    <= 1'b0;
                    align_cnt <= '0;
                    if (link_en_i) begin
                        enc_data_o   <= K28_5;
                        enc_k_o      <= 1'b1;
                        enc_valid_o  <= 1'b1;
                        enc_enable_o <= 1'b1;
                        if (ALIGN_LEN == 0) begin
                            state     <= ST_IDLE;
                            aligned_o <= 1'b1;
                        end else begin
                            state     <= ST_ALIGN;
                            align_cnt <= CNT_W'(ALIGN_LEN);
                        end
                    end
                end
                ST_ALIGN: begin
                    if (!link_en_i) begin
                        state     <= ST_DISABLED;
                        align_cnt <= '0;
                    end else begin
                        enc_data_o   <= K28_5;
                        enc_k_o      <= 1'b1;
                        enc_valid_o  <= 1'b1;
                        enc_enable_o <= 1'b1;
                        if (align_cnt == CNT_W'(1)) begin
                            state     <= ST_IDLE;
                            aligned_o <= 1'b1;
                            align_cnt <= '0;
                        end else begin
                            align_cnt <= align_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (!link_en_i) begin
                        state     <= ST_DISABLED;
                        aligned_o <= 1'b0;
                    end else begin
                        enc_k_o      <= 1'b1;
                        enc_valid_o  <= 1'b1;
                        enc_enable_o <= 1'b1;
                        if (s0_valid_i || s1_valid_i) begin
                            enc_data_o <= K27_7;
                            busy_o     <= 1'b1;
                            gnt_q      <= arb_grant;
                            state      <= ST_DATA;
                        end else begin
                            enc_data_o <= K28_5;
                        end
                    end
                end
                ST_DATA: begin
                    enc_valid_o  <= 1'b1;
                    enc_enable_o <= 1'b1;
                    if (!link_en_i) begin
                        enc_data_o <= K30_7;
                        enc_k_o    <= 1'b1;
                        busy_o     <= 1'b0;
                        state      <= ST_ABORT;
                    end else if (sel_valid) begin
                        enc_data_o <= sel_data;
                        if (sel_last) begin
                            state <= ST_EOF;
                        end
                    end else begin
                        enc_data_o <= K28_5;
                        enc_k_o    <= 1'b1;
                    end
                end
                ST_EOF: begin
                    // EOF is always sent; a concurrent link drop takes effect after it.
                    enc_data_o   <= K29_7;
                    enc_k_o      <= 1'b1;
                    enc_valid_o  <= 1'b1;
                    enc_enable_o <= 1'b1;
                    busy_o       <= 1'b0;
                    if (link_en_i) begin
                        state <= ST_IDLE;
                    end else begin
                        state     <= ST_DISABLED;
                        aligned_o <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    state     <= ST_DISABLED;
                    aligned_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
                default: begin
                    state     <= ST_DISABLED;
                    aligned_o <= 1'b0;
                    busy_o    <= 1'b0;
                    align_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc8b10b_tx_ctrl.sv
// Directed bench for enc8b10b_tx_ctrl: alignment, framing, round-robin, fill, abort and reset.
module tb_enc8b10b_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic link_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    enc8b10b_tx_ctrl_if bus ();

    logic       z_s0_ready, z_s1_ready;
    logic [7:0] z_data;
    logic       z_k, z_valid, z_enable, z_aligned, z_busy;

    always #5 clk = ~clk;

    enc8b10b_tx_ctrl #(.ALIGN_LEN(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .link_en_i    (link_en),
        .s0_data_i    (bus.s0_data),
        .s0_valid_i   (bus.s0_valid),
        .s0_last_i    (bus.s0_last),
        .s0_ready_o   (bus.s0_ready),
        .s1_data_i    (bus.s1_data),
        .s1_valid_i   (bus.s1_valid),
        .s1_last_i    (bus.s1_last),
        .s1_ready_o   (bus.s1_ready),
        .enc_data_o   (bus.enc_data),
        .enc_k_o      (bus.enc_k),
        .enc_valid_o  (bus.enc_valid),
        .enc_enable_o (bus.enc_enable),
        .aligned_o    (bus.aligned),
        .busy_o       (bus.busy)
    );

    enc8b10b_tx_ctrl #(.ALIGN_LEN(0)) dut0 (
        .clk_i        (clk),
        .rst_i        (rst),
        .link_en_i    (link_en),
        .s0_data_i    (bus.s0_data),
        .s0_valid_i   (bus.s0_valid),
        .s0_last_i    (bus.s0_last),
        .s0_ready_o   (z_s0_ready),
        .s1_data_i    (bus.s1_data),
        .s1_valid_i   (bus.s1_valid),
        .s1_last_i    (bus.s1_last),
        .s1_ready_o   (z_s1_ready),
        .enc_data_o   (z_data),
        .enc_k_o      (z_k),
        .enc_valid_o  (z_valid),
        .enc_enable_o (z_enable),
        .aligned_o    (z_aligned),
        .busy_o       (z_busy)
    );

    // Present one cycle of requester inputs, sample ready before the edge, return #1 after it.
    task automatic drive_cycle(input logic v0, input logic [7:0] d0, input logic l0,
                               input logic v1, input logic [7:0] d1, input logic l1,
                               output logic r0, output logic r1);
        bus.s0_valid = v0; bus.s0_data = d0; bus.s0_last = l0;
        bus.s1_valid = v1; bus.s1_data = d1; bus.s1_last = l1;
        #1;
        r0 = bus.s0_ready;
        r1 = bus.s1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic r0, r1;
        rst = 1'b1; link_en = 1'b1;
        bus.s0_valid = 1'b1; bus.s0_data = 8'h55; bus.s0_last = 1'b0;
        bus.s1_valid = 1'b0; bus.s1_data = 8'h00; bus.s1_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.enc_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus.enc_data); end
        checks++; if (bus.enc_k !== 1'b0) begin errors++; $display("FAIL reset_k got=%b exp=0", bus.enc_k); end
        checks++; if (bus.enc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.enc_valid); end
        checks++; if (bus.enc_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", bus.enc_enable); end
        checks++; if (bus.aligned !== 1'b0) begin errors++; $display("FAIL reset_aligned got=%b exp=0", bus.aligned); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.s0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.s0_ready); end
        checks++; if (z_enable !== 1'b0 || z_s0_ready !== 1'b0) begin errors++; $display("FAIL reset_dut0 got en=%b rdy=%b exp=0,0", z_enable, z_s0_ready); end
        rst = 1'b0; link_en = 1'b0;
        drive_cycle(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL disabled_holdoff_ready got=%b exp=0", r0); end
        checks++; if (bus.enc_enable !== 1'b0) begin errors++; $display("FAIL disabled_enable got=%b exp=0", bus.enc_enable); end
    endtask

    task automatic test_align();
        logic r0, r1;
        link_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
            checks++; if (bus.enc_data !== 8'hBC || bus.enc_k !== 1'b1) begin errors++; $display("FAIL align_sym[%0d] got=%h/%b exp=bc/1", i, bus.enc_data, bus.enc_k); end
            checks++; if (bus.enc_enable !== 1'b1 || bus.enc_valid !== 1'b1) begin errors++; $display("FAIL align_en[%0d] got en=%b v=%b exp=1,1", i, bus.enc_enable, bus.enc_valid); end
            checks++; if (bus.aligned !== 1'b0) begin errors++; $display("FAIL align_aligned[%0d] got=%b exp=0", i, bus.aligned); end
            if (i == 0) begin
                checks++; if (z_aligned !== 1'b1 || z_data !== 8'hBC) begin errors++; $display("FAIL align_len0 got aligned=%b data=%h exp=1/bc", z_aligned, z_data); end
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (bus.aligned !== 1'b1) begin errors++; $display("FAIL align_done got=%b exp=1", bus.aligned); end
        checks++; if (bus.enc_data !== 8'hBC || bus.enc_k !== 1'b1) begin errors++; $display("FAIL idle_sym got=%h/%b exp=bc/1", bus.enc_data, bus.enc_k); end
    endtask

    task automatic test_back_to_back();
        logic r0, r1;
        logic [7:0] pa [2];
        logic [7:0] pb [2];
        logic [7:0] exp_d [9];
        logic       exp_k [9];
        logic       exp_r0 [9];
        logic       exp_r1 [9];
        logic       exp_b [9];
        int ia = 0;
        int ib = 0;
        pa = '{8'hA1, 8'hA2};
        pb = '{8'hB1, 8'hB2};
        exp_d  = '{8'hFB, 8'hA1, 8'hA2, 8'hFD, 8'hFB, 8'hB1, 8'hB2, 8'hFD, 8'hBC};
        exp_k  = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
        exp_r0 = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
        exp_r1 = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        exp_b  = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            drive_cycle(ia < 2, pa[ia > 1 ? 1 : ia], ia == 1, ib < 2, pb[ib > 1 ? 1 : ib], ib == 1, r0, r1);
            if (r0 && ia < 2) ia++;
            if (r1 && ib < 2) ib++;
            checks++; if (bus.enc_data !== exp_d[i] || bus.enc_k !== exp_k[i]) begin errors++; $display("FAIL rr_sym[%0d] got=%h/%b exp=%h/%b", i, bus.enc_data, bus.enc_k, exp_d[i], exp_k[i]); end
            checks++; if (r0 !== exp_r0[i] || r1 !== exp_r1[i]) begin errors++; $display("FAIL rr_ready[%0d] got=%b%b exp=%b%b", i, r0, r1, exp_r0[i], exp_r1[i]); end
            checks++; if (bus.busy !== exp_b[i]) begin errors++; $display("FAIL rr_busy[%0d] got=%b exp=%b", i, bus.busy, exp_b[i]); end
        end
    endtask

    task automatic test_single_packet();
        logic r0, r1;
        logic [7:0] pa [3];
        logic [7:0] exp_d [6];
        logic       exp_k [6];
        logic       exp_r0 [6];
        logic       exp_b [6];
        int ia = 0;
        int acc = 0;
        pa = '{8'h01, 8'h09, 8'h48};
        exp_d  = '{8'hFB, 8'h01, 8'h09, 8'h48, 8'hFD, 8'hBC};
        exp_k  = '{1, 0, 0, 0, 1, 1};
        exp_r0 = '{0, 1, 1, 1, 0, 0};
        exp_b  = '{1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(ia < 3, pa[ia > 2 ? 2 : ia], ia == 2, 1'b0, 8'h00, 1'b0, r0, r1);
            if (r0 && ia < 3) begin ia++; acc++; end
            checks++; if (bus.enc_data !== exp_d[i] || bus.enc_k !== exp_k[i]) begin errors++; $display("FAIL pkt_sym[%0d] got=%h/%b exp=%h/%b", i, bus.enc_data, bus.enc_k, exp_d[i], exp_k[i]); end
            checks++; if (r0 !== exp_r0[i] || r1 !== 1'b0) begin errors++; $display("FAIL pkt_ready[%0d] got=%b%b exp=%b0", i, r0, r1, exp_r0[i]); end
            checks++; if (bus.busy !== exp_b[i]) begin errors++; $display("FAIL pkt_busy[%0d] got=%b exp=%b", i, bus.busy, exp_b[i]); end
        end
        checks++; if (acc !== 3) begin errors++; $display("FAIL pkt_accepted got=%0d exp=3", acc); end
    endtask

    task automatic test_fill();
        logic r0, r1;
        logic [7:0] pa [3];
        logic       mask [8];
        logic [7:0] exp_d [8];
        logic       exp_k [8];
        logic       exp_b [8];
        int ia = 0;
        pa = '{8'h11, 8'h22, 8'h33};
        mask  = '{1, 1, 0, 0, 1, 1, 1, 1};
        exp_d = '{8'hFB, 8'h11, 8'hBC, 8'hBC, 8'h22, 8'h33, 8'hFD, 8'hBC};
        exp_k = '{1, 0, 1, 1, 0, 0, 1, 1};
        exp_b = '{1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(mask[i] && ia < 3, pa[ia > 2 ? 2 : ia], ia == 2, 1'b0, 8'h00, 1'b0, r0, r1);
            if (r0 && mask[i] && ia < 3) ia++;
            checks++; if (bus.enc_data !== exp_d[i] || bus.enc_k !== exp_k[i]) begin errors++; $display("FAIL fill_sym[%0d] got=%h/%b exp=%h/%b", i, bus.enc_data, bus.enc_k, exp_d[i], exp_k[i]); end
            checks++; if (bus.busy !== exp_b[i]) begin errors++; $display("FAIL fill_busy[%0d] got=%b exp=%b", i, bus.busy, exp_b[i]); end
        end
    endtask

    task automatic test_abort();
        logic r0, r1;
        link_en = 1'b1;
        drive_cycle(1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (bus.enc_data !== 8'hFB) begin errors++; $display("FAIL abort_sof got=%h exp=fb", bus.enc_data); end
        drive_cycle(1'b1, 8'hC1, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        drive_cycle(1'b1, 8'hC2, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (bus.enc_data !== 8'hC2 || bus.enc_k !== 1'b0) begin errors++; $display("FAIL abort_byte2 got=%h/%b exp=c2/0", bus.enc_data, bus.enc_k); end
        link_en = 1'b0;
        drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL abort_no_accept got=%b exp=0", r0); end
        checks++; if (bus.enc_data !== 8'hFE || bus.enc_k !== 1'b1 || bus.enc_enable !== 1'b1) begin errors++; $display("FAIL abort_sym got=%h/%b en=%b exp=fe/1 en=1", bus.enc_data, bus.enc_k, bus.enc_enable); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (bus.enc_enable !== 1'b0 || bus.enc_valid !== 1'b0 || bus.aligned !== 1'b0) begin errors++; $display("FAIL abort_disabled got en=%b v=%b al=%b exp=0,0,0", bus.enc_enable, bus.enc_valid, bus.aligned); end
        link_en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
            checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL realign_holdoff[%0d] got=%b exp=0", j, r0); end
            checks++; if (bus.enc_data !== 8'hBC || bus.aligned !== 1'b0) begin errors++; $display("FAIL realign_sym[%0d] got=%h al=%b exp=bc al=0", j, bus.enc_data, bus.aligned); end
        end
        drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (bus.aligned !== 1'b1) begin errors++; $display("FAIL realign_done got=%b exp=1", bus.aligned); end
        drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (bus.enc_data !== 8'hFB) begin errors++; $display("FAIL resume_sof got=%h exp=fb", bus.enc_data); end
        drive_cycle(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (r0 !== 1'b1 || bus.enc_data !== 8'hC3) begin errors++; $display("FAIL resume_held_byte got rdy=%b data=%h exp=1/c3", r0, bus.enc_data); end
        drive_cycle(1'b1, 8'hC4, 1'b1, 1'b0, 8'h00, 1'b0, r0, r1);
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, r0, r1);
        checks++; if (bus.enc_data !== 8'hFD || bus.enc_k !== 1'b1) begin errors++; $display("FAIL resume_eof got=%h/%b exp=fd/1", bus.enc_data, bus.enc_k); end
    endtask

    task automatic test_reset_mid_packet();
        logic r0, r1;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hD1, 1'b0, r0, r1);
        checks++; if (bus.enc_data !== 8'hFB) begin errors++; $display("FAIL rstpkt_sof got=%h exp=fb", bus.enc_data); end
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hD1, 1'b0, r0, r1);
        checks++; if (r1 !== 1'b1 || bus.enc_data !== 8'hD1) begin errors++; $display("FAIL rstpkt_byte got rdy=%b data=%h exp=1/d1", r1, bus.enc_data); end
        rst = 1'b1;
        drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, 8'hD2, 1'b0, r0, r1);
        checks++; if (bus.enc_data !== 8'h00 || bus.enc_k !== 1'b0 || bus.enc_valid !== 1'b0 || bus.enc_enable !== 1'b0) begin errors++; $display("FAIL rstpkt_outs got=%h/%b v=%b en=%b exp=00/0 v=0 en=0", bus.enc_data, bus.enc_k, bus.enc_valid, bus.enc_enable); end
        checks++; if (bus.busy !== 1'b0 || bus.aligned !== 1'b0 || bus.s1_ready !== 1'b0) begin errors++; $display("FAIL rstpkt_status got busy=%b al=%b rdy=%b exp=0,0,0", bus.busy, bus.aligned, bus.s1_ready); end
        rst = 1'b0;
        for (int j = 0; j < 16; j++) begin
            drive_cycle(1'b1, 8'hE0, 1'b1, 1'b1, 8'hD2, 1'b0, r0, r1);
            checks++; if (bus.enc_data !== 8'hBC || bus.enc_k !== 1'b1) begin errors++; $display("FAIL rstpkt_no_abort[%0d] got=%h/%b exp=bc/1", j, bus.enc_data, bus.enc_k); end
        end
        drive_cycle(1'b1, 8'hE0, 1'b1, 1'b1, 8'hD2, 1'b0, r0, r1);
        drive_cycle(1'b1, 8'hE0, 1'b1, 1'b1, 8'hD2, 1'b0, r0, r1);
        checks++; if (bus.enc_data !== 8'hFB) begin errors++; $display("FAIL rstpkt_resof got=%h exp=fb", bus.enc_data); end
        drive_cycle(1'b1, 8'hE0, 1'b1, 1'b1, 8'hD2, 1'b0, r0, r1);
        checks++; if (r0 !== 1'b1 || r1 !== 1'b0 || bus.enc_data !== 8'hE0) begin errors++; $display("FAIL rstpkt_ptr_s0 got rdy=%b%b data=%h exp=10/e0", r0, r1, bus.enc_data); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_align();
        test_back_to_back();
        test_single_packet();
        test_fill();
        test_abort();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
